// File: rtl/memory_stage.sv
// Memory pipeline stage: passes ALU results to writeback, or runs one data-memory
// access per load/store with a bounded wait and a sticky timeout flag.
module memory_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] dest_reg_value_ixmem_p4,
    input  logic [2:0]  dest_reg_index_ixmem_p4,
    input  logic        dest_reg_write_valid_ixmem_p4,
    input  logic [15:0] mem_addr_ixmem_p4,
    input  logic        ldst_valid_ixmem_p4,
    input  logic [1:0]  store_valid_ixmem_p4,
    input  logic [15:0] mem_data_in_ixmem_p4,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    output logic        mem_stall,
    output logic        mem_err,
    output logic [2:0]  dest_reg_index_memwb_p5,
    output logic [15:0] dest_reg_value_memwb_p5,
    output logic        dest_reg_write_valid_memwb_p5
);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    localparam logic [1:0] OpLoad      = 2'b00;
    localparam logic [1:0] OpStoreUpd  = 2'b10;
    localparam logic [7:0] CntLast     = 8'(TIMEOUT - 1);

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic [2:0]  idx_q;
    logic [1:0]  op_q;
    logic        req_q;
    logic        we_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        err_q;
    logic [2:0]  p5_idx_q;
    logic [15:0] p5_val_q;
    logic        p5_wv_q;
    logic        timeout_hit;

    assign timeout_hit = (state_q == StAccess) && !dmem_ack && (cnt_q == CntLast);

    // Stall is released on the completing or aborting cycle so upstream advances with us.
    always_comb begin
        mem_stall = 1'b0;
        if (!rst) begin
            unique case (state_q)
                StIdle:   mem_stall = ldst_valid_ixmem_p4;
                StAccess: mem_stall = !dmem_ack && !timeout_hit;
                default:  mem_stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= 8'd0;
            idx_q    <= 3'd0;
            op_q     <= 2'd0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 16'd0;
            wdata_q  <= 16'd0;
            err_q    <= 1'b0;
            p5_idx_q <= 3'd0;
            p5_val_q <= 16'd0;
            p5_wv_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ldst_valid_ixmem_p4) begin
                        state_q <= StAccess;
                        cnt_q   <= 8'd0;
                        idx_q   <= dest_reg_index_ixmem_p4;
                        op_q    <= store_valid_ixmem_p4;
                        req_q   <= 1'b1;
                        we_q    <= |store_valid_ixmem_p4;
                        addr_q  <= mem_addr_ixmem_p4;
                        wdata_q <= mem_data_in_ixmem_p4;
                        p5_wv_q <= 1'b0;
                    end else begin
                        p5_idx_q <= dest_reg_index_ixmem_p4;
                        p5_val_q <= dest_reg_value_ixmem_p4;
                        p5_wv_q  <= dest_reg_write_valid_ixmem_p4;
                    end
                end
                StAccess: begin
                    if (dmem_ack || timeout_hit) begin
                        state_q <= StIdle;
                        cnt_q   <= 8'd0;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        addr_q  <= 16'd0;
                        wdata_q <= 16'd0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                    if (dmem_ack) begin
                        p5_idx_q <= idx_q;
                        if (op_q == OpLoad) begin
                            p5_val_q <= dmem_rdata;
                            p5_wv_q  <= 1'b1;
                        end else if (op_q == OpStoreUpd) begin
                            p5_val_q <= addr_q;
                            p5_wv_q  <= 1'b1;
                        end else begin
                            p5_val_q <= addr_q;
                            p5_wv_q  <= 1'b0;
                        end
                    end else begin
                        p5_wv_q <= 1'b0;
                        if (timeout_hit) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign dmem_req                      = req_q;
    assign dmem_we                       = we_q;
    assign dmem_addr                     = addr_q;
    assign dmem_wdata                    = wdata_q;
    assign mem_err                       = err_q;
    assign dest_reg_index_memwb_p5       = p5_idx_q;
    assign dest_reg_value_memwb_p5       = p5_val_q;
    assign dest_reg_write_valid_memwb_p5 = p5_wv_q;

endmodule
